// File: rtl/interconn_arbiter.sv
// interconn_arbiter: front-end scheduler for the MVU interconnect crossbar.
// Each cycle it grants a conflict-free set of source requests under rotating
// priority, then drives the crossbar send_* inputs from registers.
//
// Ports:
//   clk, clr            clock, asynchronous active-high reset
//   req_valid/req_ready valid/ready handshake per source (ready is combinational)
//   req_dst             per-source destination mask, slice [i*N +: N]
//   req_addr/req_word   per-source address and data payload
//   hold                1 = grant nothing this cycle
//   send_en/to/addr/word registered crossbar drive, one cycle after acceptance
//   conflict_cnt        saturating count of cycles with a blocked valid request
//   err_nodst           sticky: a request with an all-zero mask was accepted
//   err_clr             synchronous clear of err_nodst and conflict_cnt
module interconn_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 64,
  parameter int unsigned BADDR = 15,
  parameter int unsigned CW    = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*N-1:0]     req_dst,
  input  logic [N*BADDR-1:0] req_addr,
  input  logic [N*W-1:0]     req_word,
  input  logic               hold,
  output logic [N-1:0]       send_en,
  output logic [N*N-1:0]     send_to,
  output logic [N*BADDR-1:0] send_addr,
  output logic [N*W-1:0]     send_word,
  output logic [CW-1:0]      conflict_cnt,
  output logic               err_nodst,
  input  logic               err_clr
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int          NI = int'(N);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N-1:0]       grant;
  logic [N-1:0]       claimed;
  logic [N-1:0]       has_dst;
  logic               found;
  logic               blocked;
  logic               nodst_acc;
  logic [N-1:0]       send_en_d;
  logic [N*N-1:0]     send_to_d;
  logic [N*BADDR-1:0] send_addr_d;
  logic [N*W-1:0]     send_word_d;

  // Rotating-priority greedy grant. The outer loop walks visit positions so
  // that the claimed mask accumulates in priority order starting at ptr_q.
  always_comb begin
    grant   = '0;
    claimed = '0;
    found   = 1'b0;
    ptr_d   = ptr_q;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (((i + NI - int'(ptr_q)) % NI) == k && !hold && req_valid[i] &&
            ((req_dst[i*NI +: NI] & claimed) == '0)) begin
          grant[i] = 1'b1;
          claimed  = claimed | req_dst[i*NI +: NI];
          // Pointer moves just past the first source granted in visit order.
          if (!found) begin
            found = 1'b1;
            ptr_d = PW'((i + 1) % NI);
          end
        end
      end
    end
  end

  assign req_ready = grant;

  always_comb begin
    has_dst     = '0;
    send_en_d   = '0;
    send_to_d   = '0;
    send_addr_d = '0;
    send_word_d = '0;
    for (int i = 0; i < NI; i++) begin
      has_dst[i]   = |req_dst[i*NI +: NI];
      send_en_d[i] = grant[i] & has_dst[i];
      if (send_en_d[i]) begin
        send_to_d[i*NI +: NI]                 = req_dst[i*NI +: NI];
        send_addr_d[i*int'(BADDR) +: BADDR]   = req_addr[i*int'(BADDR) +: BADDR];
        send_word_d[i*int'(W) +: W]           = req_word[i*int'(W) +: W];
      end
    end
  end

  assign blocked   = !hold && |(req_valid & ~grant);
  // Zero-mask requests are accepted but never reach the crossbar.
  assign nodst_acc = |(grant & ~has_dst);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_q        <= '0;
      send_en      <= '0;
      send_to      <= '0;
      send_addr    <= '0;
      send_word    <= '0;
      conflict_cnt <= '0;
      err_nodst    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      send_en   <= send_en_d;
      send_to   <= send_to_d;
      send_addr <= send_addr_d;
      send_word <= send_word_d;
      if (err_clr) begin
        conflict_cnt <= '0;
        err_nodst    <= 1'b0;
      end else begin
        if (blocked && (conflict_cnt != '1)) begin
          conflict_cnt <= conflict_cnt + CW'(1);
        end
        if (nodst_acc) begin
          err_nodst <= 1'b1;
        end
      end
    end
  end

endmodule
